counter_sched: RTL and testbench

- Round-robin scheduler that shares one external 4-bit up-counter (sync clear, count enable, Q output) among N_REQ requesters.
- Each requester asks for a delay of DUR counts. The block clears the counter, enables it until Q equals DUR, then pulses a per-requester done.
- Sits between timing clients and the shared counter instance; it is the only driver of the counter's EN and CLR.

---
 rtl/counter_sched.sv | 125 ++++++++++++
 tb/tb_counter_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one external up-counter among N_REQ timing clients.
// Each granted client gets the counter cleared, then enabled until Q reaches its duration.
module counter_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   CLR_N,
  input  logic [N_REQ-1:0]       REQ_IN,
  input  logic [N_REQ*WIDTH-1:0] DUR_IN,
  input  logic [WIDTH-1:0]       CNT_Q_IN,
  output logic                   CNT_EN_OUT,
  output logic                   CNT_CLR_OUT,
  output logic [N_REQ-1:0]       GNT_OUT,
  output logic [N_REQ-1:0]       DONE_OUT,
  output logic                   BUSY_OUT
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  dur_q, dur_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW:0]     cand;
  logic [WIDTH-1:0]  win_dur;
  logic              req_held;
  logic              cnt_match;

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
    if (32'(i) == N_REQ - 1) return '0;
    return i + IdxW'(1);
  endfunction

  // Scan ptr, ptr+1, ... modulo N_REQ; first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(N_REQ)) cand = cand - (IdxW+1)'(N_REQ);
      if (!win_found && REQ_IN[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign win_dur   = DUR_IN[32'(win_idx)*WIDTH +: WIDTH];
  assign req_held  = REQ_IN[idx_q];
  assign cnt_match = (CNT_Q_IN == dur_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    gnt_d   = gnt_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d   = win_idx;
          dur_d   = win_dur;
          gnt_d   = N_REQ'(1) << win_idx;
          state_d = StClear;
        end
      end
      StClear: begin
        if (!req_held) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = inc_idx(idx_q);
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A dropped request aborts even if the count completes this cycle.
        if (!req_held) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = inc_idx(idx_q);
        end else if (cnt_match) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        ptr_d   = inc_idx(idx_q);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      dur_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      gnt_q   <= gnt_d;
    end
  end

  assign GNT_OUT     = gnt_q;
  assign DONE_OUT    = (state_q == StDone) ? gnt_q : '0;
  assign BUSY_OUT    = (state_q != StIdle);
  assign CNT_CLR_OUT = (state_q == StClear);
  assign CNT_EN_OUT  = (state_q == StRun) && req_held && !cnt_match;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural 4-bit counter standing in
// for the shared external counter instance.
module tb_counter_sched;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic           CLK;
  logic           CLR_N;
  logic [N-1:0]   REQ_IN;
  logic [N*W-1:0] DUR_IN;
  logic [W-1:0]   CNT_Q_IN;
  logic           CNT_EN_OUT;
  logic           CNT_CLR_OUT;
  logic [N-1:0]   GNT_OUT;
  logic [N-1:0]   DONE_OUT;
  logic           BUSY_OUT;

  int n_assert;
  int n_fail;

  counter_sched #(
    .N_REQ(N),
    .WIDTH(W)
  ) dut (
    .CLK        (CLK),
    .CLR_N      (CLR_N),
    .REQ_IN     (REQ_IN),
    .DUR_IN     (DUR_IN),
    .CNT_Q_IN   (CNT_Q_IN),
    .CNT_EN_OUT (CNT_EN_OUT),
    .CNT_CLR_OUT(CNT_CLR_OUT),
    .GNT_OUT    (GNT_OUT),
    .DONE_OUT   (DONE_OUT),
    .BUSY_OUT   (BUSY_OUT)
  );

  // Shared counter: no reset, sync clear, count enable.
  always_ff @(posedge CLK) begin
    if (CNT_CLR_OUT) CNT_Q_IN <= '0;
    else if (CNT_EN_OUT) CNT_Q_IN <= CNT_Q_IN + 4'd1;
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge in IDLE with the request already applied.
  // Returns at the falling edge inside the DONE cycle.
  task automatic job(input int idx, input int dur, input bit scramble, input string tag);
    int run_cyc;
    int en_cnt;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    tick();
    chk({tag, "_gnt"}, 32'(GNT_OUT), 32'(oh));
    chk({tag, "_clr"}, 32'(CNT_CLR_OUT), 32'd1);
    chk({tag, "_en_in_clear"}, 32'(CNT_EN_OUT), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY_OUT), 32'd1);
    if (scramble) DUR_IN = ~DUR_IN;
    run_cyc = 0;
    en_cnt  = 0;
    tick();
    while (DONE_OUT == '0 && run_cyc < 40) begin
      if (CNT_EN_OUT) en_cnt++;
      run_cyc++;
      tick();
    end
    chk({tag, "_done"}, 32'(DONE_OUT), 32'(oh));
    chk({tag, "_run_cycles"}, 32'(run_cyc), 32'(dur + 1));
    chk({tag, "_en_cycles"}, 32'(en_cnt), 32'(dur));
    chk({tag, "_q"}, 32'(CNT_Q_IN), 32'(dur));
    chk({tag, "_gnt_held"}, 32'(GNT_OUT), 32'(oh));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    CLR_N    = 1'b0;
    REQ_IN   = '0;
    DUR_IN   = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(GNT_OUT), 32'd0);
    chk("rst_done", 32'(DONE_OUT), 32'd0);
    chk("rst_busy", 32'(BUSY_OUT), 32'd0);
    chk("rst_en", 32'(CNT_EN_OUT), 32'd0);
    chk("rst_clr", 32'(CNT_CLR_OUT), 32'd0);
    CLR_N = 1'b1;

    // Single job, requester 0, duration 3.
    REQ_IN = 4'b0001;
    DUR_IN = 16'h0003;
    job(0, 3, 1'b0, "single");
    REQ_IN = '0;
    tick();
    chk("single_busy_drop", 32'(BUSY_OUT), 32'd0);
    chk("single_gnt_drop", 32'(GNT_OUT), 32'd0);
    chk("single_done_drop", 32'(DONE_OUT), 32'd0);

    // Reset pointer, then all four request continuously.
    CLR_N = 1'b0;
    tick();
    CLR_N  = 1'b1;
    REQ_IN = 4'b1111;
    DUR_IN = 16'h1111;
    job(0, 1, 1'b0, "rr0");
    tick();
    chk("rr_gap0", 32'(BUSY_OUT), 32'd0);
    job(1, 1, 1'b0, "rr1");
    tick();
    chk("rr_gap1", 32'(BUSY_OUT), 32'd0);
    job(2, 1, 1'b0, "rr2");
    tick();
    chk("rr_gap2", 32'(BUSY_OUT), 32'd0);
    job(3, 1, 1'b0, "rr3");
    tick();
    chk("rr_gap3", 32'(BUSY_OUT), 32'd0);
    job(0, 1, 1'b0, "rr4");
    REQ_IN = '0;
    tick();

    // Duration boundaries on requester 2; the max job has DUR_IN rewritten after grant.
    REQ_IN = 4'b0100;
    DUR_IN = 16'h0000;
    job(2, 0, 1'b0, "dur0");
    DUR_IN = 16'h0F00;
    tick();
    chk("dur_gap", 32'(BUSY_OUT), 32'd0);
    job(2, 15, 1'b1, "dur15");
    REQ_IN = '0;
    tick();
    chk("dur15_nowrap", 32'(CNT_Q_IN), 32'd15);
    chk("dur15_idle", 32'(BUSY_OUT), 32'd0);

    // Abort: pointer is 3, requesters 1 and 2 ask; 1 wins and drops at Q=2.
    DUR_IN = 16'h0190;
    REQ_IN = 4'b0110;
    tick();
    chk("abort_gnt", 32'(GNT_OUT), 32'b0010);
    tick();
    tick();
    tick();
    chk("abort_q2", 32'(CNT_Q_IN), 32'd2);
    chk("abort_en_before", 32'(CNT_EN_OUT), 32'd1);
    REQ_IN = 4'b0100;
    #1;
    chk("abort_en_comb", 32'(CNT_EN_OUT), 32'd0);
    chk("abort_no_done", 32'(DONE_OUT), 32'd0);
    tick();
    chk("abort_gnt_clear", 32'(GNT_OUT), 32'd0);
    chk("abort_idle", 32'(BUSY_OUT), 32'd0);
    chk("abort_no_done2", 32'(DONE_OUT), 32'd0);
    job(2, 1, 1'b0, "after_abort");

    // Asynchronous reset mid-RUN, then a fresh job must re-clear the counter.
    REQ_IN = 4'b0001;
    DUR_IN = 16'h0005;
    tick();
    tick();
    chk("mid_gnt", 32'(GNT_OUT), 32'b0001);
    tick();
    tick();
    tick();
    chk("mid_q2", 32'(CNT_Q_IN), 32'd2);
    #2 CLR_N = 1'b0;
    #1;
    chk("arst_gnt", 32'(GNT_OUT), 32'd0);
    chk("arst_busy", 32'(BUSY_OUT), 32'd0);
    chk("arst_en", 32'(CNT_EN_OUT), 32'd0);
    chk("arst_clr", 32'(CNT_CLR_OUT), 32'd0);
    chk("arst_done", 32'(DONE_OUT), 32'd0);
    #1 CLR_N = 1'b1;
    job(0, 5, 1'b0, "post_rst");

    // Move pointer to 3, then requesters 0 and 3 compete.
    REQ_IN = 4'b0100;
    DUR_IN = 16'h0000;
    tick();
    job(2, 0, 1'b0, "ptr_setup");
    REQ_IN = 4'b1001;
    tick();
    chk("done_drop_no_effect", 32'(BUSY_OUT), 32'd0);
    job(3, 0, 1'b0, "ptr3_win");
    tick();
    job(0, 0, 1'b0, "ptr0_win");
    REQ_IN = '0;
    tick();
    chk("final_gnt", 32'(GNT_OUT), 32'd0);
    chk("final_busy", 32'(BUSY_OUT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
